// File: rtl/mmio_uart_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets (address bits [4:3]), STATUS bit positions and the TX FSM states.
// The PARITY state is only reached when MMIO_UART_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_PAR     = 4;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through output.
// Ports:
//   clock, reset : clock and synchronous active-high reset (pointers/count)
//   push, din    : write request and data; ignored while full
//   pop, dout    : read request and head-of-queue data; ignored while empty
//   full, empty  : occupancy flags derived from count
//   count        : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // Fullness is judged at the start of the cycle: a push while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only; no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the core's data-memory port.
// Register window (32 bytes at BASE_ADDR, 8-byte aligned accesses only):
//   0x00 TXDATA  W: push write_data[7:0]        R: 0
//   0x08 STATUS  R: full/empty/fsm_busy/ovf/parity_en, count in [23:8]
//                W: 1 to bit3 clears overflow
//   0x10 CTRL    bit0 enable (resets to 1)
//   0x18 reserved
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   mem_write, mem_read   : store / load strobes
//   address, write_data   : byte address and store data
//   read_data             : combinational load data (0 unless a valid read)
//   sel                   : combinational window hit (ignores alignment)
//   tx                    : UART line, idles high
//   busy                  : FSM active or FIFO non-empty
// Build option: define MMIO_UART_TX_PARITY_EN to append an even-parity bit
// (8E1 framing); default build is 8N1.
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    // Address decode
    logic       hit, acc;
    logic [1:0] offset;
    logic       wr_txdata, wr_status, wr_ctrl;

    assign hit       = (address[63:5] == BASE_ADDR[63:5]);
    assign acc       = hit && (address[2:0] == 3'b000);
    assign offset    = address[4:3];
    assign sel       = hit;
    assign wr_txdata = mem_write && acc && (offset == OFF_TXDATA);
    assign wr_status = mem_write && acc && (offset == OFF_STATUS);
    assign wr_ctrl   = mem_write && acc && (offset == OFF_CTRL);

    wire unused_wdata = ^write_data[63:8];

    // FIFO
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Control registers
    logic enable_q, enable_d;
    logic ovf_q, ovf_d;

    assign enable_d = wr_ctrl ? write_data[0] : enable_q;
    // A new overflow wins over a same-cycle clear.
    assign ovf_d    = (ovf_q && !(wr_status && write_data[ST_OVF])) ||
                      (wr_txdata && fifo_full);

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    // TX FSM
    uart_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
        end
        shift_q  <= shift_d;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    if (enable_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (fifo_pop) shift_d = fifo_dout;
        // Timer idles at 0 so a new frame starts with a full-length start bit.
        timer_d = (state_q == IDLE || bit_end) ? '0 : timer_q + TW'(1);
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d = fifo_pop ? ^fifo_dout : parity_q;
`endif
    end

    // Output logic
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE) || !fifo_empty;

    // Read mux
    logic [63:0] status_w;

    always_comb begin
        status_w                                 = '0;
        status_w[ST_FULL]                        = fifo_full;
        status_w[ST_EMPTY]                       = fifo_empty;
        status_w[ST_BUSY]                        = (state_q != IDLE);
        status_w[ST_OVF]                         = ovf_q;
        status_w[ST_PAR]                         = PAR_EN;
        status_w[ST_CNT_LSB +: ST_CNT_W]         = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        if (mem_read && acc) begin
            case (offset)
                OFF_STATUS: read_data = status_w;
                OFF_CTRL:   read_data = {63'd0, enable_q};
                default:    read_data = '0;
            endcase
        end
    end

endmodule
